mod_count_ctrl: RTL and testbench
=================================

Name: mod_count_ctrl

Overview:
- Controller and sequencer for a single programmable modulo-N counter.
- Accepts a modulus and mode through a valid/ready config handshake, then runs the counter periodically or one-shot under start/stop control.
- Emits a terminal-count pulse on every wrap.
- Used wherever the design needs a runtime-selectable mod-3/5/7/8/16-style count instead of fixed hard-wired counters.

Parameters:
- WIDTH, 5, bit width of the modulus and count registers; legal modulus range is 2..2^WIDTH-1.
- DEFAULT_MOD, 16, modulus loaded at reset; must be in 2..2^WIDTH-1.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted this cycle.
- cfg_mod  in  WIDTH  requested modulus.
- cfg_oneshot  in  1  1 = stop after one full period; 0 = periodic.
- start  in  1  start-counting pulse.
- stop  in  1  abort-counting pulse.
- count  out  WIDTH  current count value.
- tc  out  1  terminal-count pulse, one cycle wide.
- busy  out  1  high while in RUN.
- done  out  1  high after a one-shot period completes.
- err  out  1  sticky illegal-config flag.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, count=0, mod_reg=DEFAULT_MOD, oneshot_reg=0, tc=0, done=0, err=0, busy=0, cfg_ready=1.
- Reset behaviour: rst asserted at any time, including mid-RUN, forces all reset values at the next edge. rst overrides every other input.
- States: IDLE, RUN, DONE.
- cfg_ready is combinational: it is 1 in IDLE or DONE and 0 in RUN.
- Config accept: occurs when cfg_valid && cfg_ready.
  - If cfg_mod >= 2: mod_reg<=cfg_mod, oneshot_reg<=cfg_oneshot, count<=0, err<=0, done<=0. State goes to IDLE.
  - If cfg_mod < 2: config is rejected. mod_reg and oneshot_reg are unchanged, err<=1, and the state is unchanged.
  - cfg_valid in RUN is not accepted and has no effect.
- start in IDLE/DONE: state<=RUN, count<=0, done<=0.
  - If a config handshake occurs in the same cycle, the config wins and start is ignored.
  - start in RUN is ignored.
- RUN, normal cycle: count increments by 1 each cycle.
- RUN, wrap (count==mod_reg-1 and no stop): count<=0 and tc<=1 for exactly one cycle, coincident with count==0.
  - If oneshot_reg=1: state<=DONE, done<=1. done stays high until the next start or accepted config.
- RUN, stop: state<=IDLE and count holds its current value.
  - stop has priority over wrap: no tc and no done; count holds mod_reg-1.
- stop in IDLE/DONE: no effect. If start and stop are both high in IDLE, start acts.
- Counter timing:
  - Period is exactly mod_reg cycles.
  - count is registered; the first cycle in RUN shows count=0.
  - tc is registered and otherwise 0.
- busy is combinational: state==RUN.
- Arithmetic: mod_reg-1 is computed in WIDTH bits and cannot underflow, because mod_reg >= 2 always holds.

Decomposition:
- Package mod_count_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - constant MIN_MOD=2.
- No sub-module. The counter datapath is small enough to sit inline with the FSM in a single module.

Test Plan:
1. Release rst, pulse start with no config → busy=1, count 0..15 repeating; tc high when count returns to 0, every 16 cycles.
2. cfg mod=3, oneshot=0, then start → count 0,1,2,0,1,2...; tc every 3rd cycle; cfg_valid during RUN keeps cfg_ready=0 and the modulus is unchanged.
3. cfg mod=5, oneshot=1, then start → count 0..4, then count=0, tc one pulse, done=1, busy=0, cfg_ready=1; a second start clears done and reruns.
4. cfg mod=1 → err=1, mod_reg stays 5; start counts mod 5. Then cfg mod=7 → err=0, counts mod 7.
5. mod=7, stop at count=2 → IDLE, count holds 2; restart → count from 0. stop in the same cycle as count=6 → no tc, count holds 6.
6. mod=16, assert rst at count=9 → next edge count=0, busy=0, tc=0, done=0, err=0; mod_reg back to 16. Also: start and cfg_valid in the same IDLE cycle → config taken, state stays IDLE.

Source files
------------

// File: rtl/mod_count_pkg.sv
// Shared types and constants for the programmable modulo-N counter controller.
package mod_count_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest modulus that still produces a counting sequence.
    localparam int MIN_MOD = 2;

endpackage

// File: rtl/mod_count_ctrl.sv
// Modulo-N counter with valid/ready configuration, start/stop sequencing,
// periodic or one-shot operation and a registered terminal-count pulse.
module mod_count_ctrl
    import mod_count_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int DEFAULT_MOD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_mod,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] mod_reg, mod_n;
    logic             oneshot_reg, oneshot_n;
    logic             tc_n, done_n, err_n;

    logic             cfg_fire;
    logic             cfg_legal;
    logic             at_wrap;

    assign cfg_ready = (state != RUN);
    assign busy      = (state == RUN);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_legal = (cfg_mod >= WIDTH'(MIN_MOD));
    // mod_reg never drops below MIN_MOD, so this subtraction cannot wrap.
    assign at_wrap   = (count == (mod_reg - WIDTH'(1)));

    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_n   = state;
        count_n   = count;
        mod_n     = mod_reg;
        oneshot_n = oneshot_reg;
        tc_n      = 1'b0;
        done_n    = done;
        err_n     = err;

        unique case (state)
            IDLE, DONE: begin
                // A config handshake, legal or not, takes precedence over start.
                if (cfg_fire) begin
                    if (cfg_legal) begin
                        mod_n     = cfg_mod;
                        oneshot_n = cfg_oneshot;
                        count_n   = '0;
                        err_n     = 1'b0;
                        done_n    = 1'b0;
                        state_n   = IDLE;
                    end else begin
                        err_n     = 1'b1;
                    end
                end else if (start) begin
                    state_n = RUN;
                    count_n = '0;
                    done_n  = 1'b0;
                end
            end

            RUN: begin
                // stop beats wrap: count freezes and no tc/done is produced.
                if (stop) begin
                    state_n = IDLE;
                end else if (at_wrap) begin
                    count_n = '0;
                    tc_n    = 1'b1;
                    if (oneshot_reg) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end else begin
                    count_n = count + WIDTH'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            mod_reg     <= WIDTH'(DEFAULT_MOD);
            oneshot_reg <= 1'b0;
            tc          <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            mod_reg     <= mod_n;
            oneshot_reg <= oneshot_n;
            tc          <= tc_n;
            done        <= done_n;
            err         <= err_n;
        end
    end

endmodule

// File: tb/tb_mod_count_ctrl.sv
// Self-checking bench for mod_count_ctrl: an elapsed-time model compared every
// cycle, plus directed literal expectations along the test sequence.
module tb_mod_count_ctrl;

    localparam int WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_mod = '0;
    logic             cfg_oneshot = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tc, busy, done, err;

    int total = 0;
    int bad   = 0;

    mod_count_ctrl #(.WIDTH(WIDTH), .DEFAULT_MOD(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mod    (cfg_mod),
        .cfg_oneshot(cfg_oneshot),
        .start      (start),
        .stop       (stop),
        .count      (count),
        .tc         (tc),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: while running, count is elapsed cycles since start modulo the
    // modulus; otherwise it is a held value.
    int m_cyc     = 0;
    int m_t0      = 0;
    int m_mod     = 16;
    bit m_oneshot = 0;
    bit m_running = 0;
    int m_hold    = 0;
    bit m_tc      = 0;
    bit m_done    = 0;
    bit m_err     = 0;
    bit m_valid   = 0;

    always @(posedge clk) begin
        int cyc_old;
        int elapsed;
        cyc_old = m_cyc;
        m_cyc   = m_cyc + 1;
        m_tc    = 0;
        if (rst) begin
            m_mod = 16; m_oneshot = 0; m_running = 0; m_hold = 0;
            m_done = 0; m_err = 0; m_valid = 1;
        end else if (!m_running) begin
            if (cfg_valid) begin
                if (int'(cfg_mod) >= 2) begin
                    m_mod = int'(cfg_mod); m_oneshot = cfg_oneshot;
                    m_hold = 0; m_err = 0; m_done = 0;
                end else begin
                    m_err = 1;
                end
            end else if (start) begin
                m_running = 1; m_t0 = m_cyc; m_done = 0;
            end
        end else if (stop) begin
            m_running = 0;
            m_hold    = (cyc_old - m_t0) % m_mod;
        end else begin
            elapsed = m_cyc - m_t0;
            m_tc    = (elapsed % m_mod) == 0;
            if (m_oneshot && elapsed == m_mod) begin
                m_running = 0; m_done = 1; m_hold = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_count", int'(count),
                  m_running ? (m_cyc - m_t0) % m_mod : m_hold);
            check("model_tc", int'(tc), int'(m_tc));
            check("model_busy", int'(busy), int'(m_running));
            check("model_cfg_ready", int'(cfg_ready), int'(!m_running));
            check("model_done", int'(done), int'(m_done));
            check("model_err", int'(err), int'(m_err));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_cfg(input int m, input bit os);
        cfg_valid = 1'b1; cfg_mod = WIDTH'(m); cfg_oneshot = os;
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        rst = 1'b0;
        step(1);
        check("reset_count", int'(count), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(cfg_ready), 1);
        check("reset_err", int'(err), 0);

        // 1: default modulus 16, periodic
        do_start();
        check("t1_first_count", int'(count), 0);
        check("t1_busy", int'(busy), 1);
        step(15);
        check("t1_count15", int'(count), 15);
        check("t1_no_tc", int'(tc), 0);
        step(1);
        check("t1_wrap_count", int'(count), 0);
        check("t1_wrap_tc", int'(tc), 1);
        step(16);
        check("t1_wrap2_tc", int'(tc), 1);
        do_stop();

        // 2: mod 3 periodic; config during RUN ignored
        do_cfg(3, 0);
        do_start();
        step(3);
        check("t2_tc", int'(tc), 1);
        check("t2_count", int'(count), 0);
        cfg_valid = 1'b1; cfg_mod = WIDTH'(9);
        check("t2_ready_in_run", int'(cfg_ready), 0);
        step(2);
        check("t2_count2", int'(count), 2);
        step(1);
        cfg_valid = 1'b0;
        check("t2_still_mod3", int'(tc), 1);
        do_stop();

        // 3: mod 5 one-shot, then rerun
        do_cfg(5, 1);
        do_start();
        step(4);
        check("t3_count4", int'(count), 4);
        step(1);
        check("t3_end_count", int'(count), 0);
        check("t3_end_tc", int'(tc), 1);
        check("t3_done", int'(done), 1);
        check("t3_busy", int'(busy), 0);
        check("t3_ready", int'(cfg_ready), 1);
        step(1);
        check("t3_tc_cleared", int'(tc), 0);
        check("t3_done_holds", int'(done), 1);
        do_start();
        check("t3_rerun_done", int'(done), 0);
        check("t3_rerun_busy", int'(busy), 1);
        step(5);
        check("t3_rerun_done2", int'(done), 1);

        // 4: illegal mod keeps mod 5 and sets err; then mod 7 clears it
        do_cfg(1, 0);
        check("t4_err", int'(err), 1);
        do_start();
        step(5);
        check("t4_mod5_tc", int'(tc), 1);
        check("t4_err_sticky", int'(err), 1);
        do_cfg(7, 0);
        check("t4_err_cleared", int'(err), 0);
        do_start();
        step(7);
        check("t4_mod7_tc", int'(tc), 1);

        // 5: stop mid-count holds, restart from 0, stop at wrap suppresses tc
        step(2);
        check("t5_count2", int'(count), 2);
        do_stop();
        check("t5_hold2", int'(count), 2);
        check("t5_idle", int'(busy), 0);
        step(2);
        check("t5_hold2_later", int'(count), 2);
        do_start();
        check("t5_restart", int'(count), 0);
        step(6);
        check("t5_count6", int'(count), 6);
        do_stop();
        check("t5_hold6", int'(count), 6);
        check("t5_no_tc", int'(tc), 0);
        check("t5_no_done", int'(done), 0);

        // 6: reset mid-run restores defaults, including modulus 16
        do_cfg(4, 1);
        do_cfg(0, 0);
        check("t6_err_set", int'(err), 1);
        do_start();
        step(1);
        check("t6_count1", int'(count), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_rst_count", int'(count), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_tc", int'(tc), 0);
        check("t6_rst_err", int'(err), 0);
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        check("t6_start_beats_stop", int'(busy), 1);
        step(9);
        check("t6_count9", int'(count), 9);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_rst2_count", int'(count), 0);
        check("t6_rst2_done", int'(done), 0);
        do_start();
        step(4);
        check("t6_default_no_tc", int'(tc), 0);
        step(12);
        check("t6_default_tc", int'(tc), 1);
        do_stop();

        // start coincident with config: config wins, state stays IDLE
        cfg_valid = 1'b1; cfg_mod = WIDTH'(6); cfg_oneshot = 1'b0; start = 1'b1;
        step(1);
        cfg_valid = 1'b0; start = 1'b0;
        check("t6_cfg_wins", int'(busy), 0);
        step(3);
        check("t6_still_idle", int'(busy), 0);
        do_start();
        step(6);
        check("t6_mod6_tc", int'(tc), 1);
        do_stop();
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
